// File: rtl/mem_copy_master.sv
// Word-copy initiator: reads LEN words from SRC and writes each one to DST over
// start/ready memory ports, with an optional per-access watchdog.
module mem_copy_master #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned LEN_WIDTH     = 8,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_src,
    input  logic [ADDRESS_WIDTH-1:0] cmd_dst,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [LEN_WIDTH-1:0]     words_done,
    output logic                     rd_start,
    output logic [ADDRESS_WIDTH-1:0] rd_address,
    input  logic                     rd_ready,
    input  logic [31:0]              rd_data,
    output logic                     wr_start,
    output logic [ADDRESS_WIDTH-1:0] wr_address,
    output logic [31:0]              wr_data,
    input  logic                     wr_ready
);

    // Wide enough to hold TIMEOUT; saturates so a disabled watchdog never wraps.
    localparam int unsigned WdW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StFinish
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] src_q, src_d;
    logic [ADDRESS_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]     rem_q, rem_d;
    logic [LEN_WIDTH-1:0]     words_q, words_d;
    logic                     error_q, error_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [WdW-1:0]           wd_q, wd_d;
    logic                     wd_expire;
    logic [WdW-1:0]           wd_inc;

    assign wd_expire = (TIMEOUT != 0) && (wd_q == WdW'(TIMEOUT - 1));
    assign wd_inc    = (wd_q == '1) ? wd_q : wd_q + WdW'(1);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            error_q <= 1'b0;
            wdata_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            error_q <= error_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic; wd_q == 0 marks the first WAIT cycle, whose ready is stale.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        words_d = words_q;
        error_d = error_q;
        wdata_d = wdata_q;
        wd_d    = wd_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    rem_d   = cmd_len;
                    words_d = '0;
                    error_d = 1'b0;
                    state_d = (cmd_len == '0) ? StFinish : StRdReq;
                end
            end
            StRdReq: begin
                wd_d = '0;
                if (rd_ready) state_d = StRdWait;
            end
            StRdWait: begin
                wd_d = wd_inc;
                if (wd_q != '0 && rd_ready) begin
                    wdata_d = rd_data;
                    state_d = StWrReq;
                end else if (wd_expire) begin
                    error_d = 1'b1;
                    state_d = StFinish;
                end
            end
            StWrReq: begin
                wd_d = '0;
                if (wr_ready) state_d = StWrWait;
            end
            StWrWait: begin
                wd_d = wd_inc;
                if (wd_q != '0 && wr_ready) begin
                    words_d = words_q + LEN_WIDTH'(1);
                    src_d   = src_q + ADDRESS_WIDTH'(4);
                    dst_d   = dst_q + ADDRESS_WIDTH'(4);
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = (rem_q == LEN_WIDTH'(1)) ? StFinish : StRdReq;
                end else if (wd_expire) begin
                    error_d = 1'b1;
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs; start pulses are suppressed while reset is asserted.
    always_comb begin
        cmd_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        done       = (state_q == StFinish);
        error      = error_q;
        words_done = words_q;
        rd_start   = !reset && (state_q == StRdReq) && rd_ready;
        wr_start   = !reset && (state_q == StWrReq) && wr_ready;
        rd_address = src_q;
        wr_address = dst_q;
        wr_data    = wdata_q;
    end

endmodule
